// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM table loader: command mode encodings, FSM
// state type, table geometry and the word-address helper.
// The verify states only exist when BRAM_LOADER_VERIFY_EN is defined.
package bram_pkg;

  localparam int         NUM_WORDS  = 8;
  localparam int         WORD_BYTES = 4;
  localparam int         IDX_W      = 3;
  localparam logic [3:0] WE_ALL     = 4'hF;

  typedef enum logic [1:0] {
    MODE_WRITE1 = 2'b00,
    MODE_FILL   = 2'b01,
    MODE_CLEAR  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
`ifdef BRAM_LOADER_VERIFY_EN
    ST_VRD   = 3'd2,
    ST_VWAIT = 3'd3,
    ST_VCMP  = 3'd4,
`endif
    ST_DONE  = 3'd5
  } loader_state_t;

  // Byte address of table word idx; wraps modulo 2^32 past the top of memory.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [IDX_W-1:0] idx);
    return base + {27'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/cmd_edge_detect.sv
// Registers the GPIO start bit and produces a one-cycle pulse on the clock
// edge where it is first sampled high after a low sample. The first sample
// after reset only primes the detector, so a level held high through reset
// does not launch a command.
module cmd_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;
  logic armed_q;

  // Previous-sample register plus a primed flag set one cycle after reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      level_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      level_q <= level;
      armed_q <= 1'b1;
    end
  end

  assign rise = armed_q & level & ~level_q;

endmodule

// File: rtl/bram_loader.sv
// GPIO-driven writer for the 8-word BRAM table. A rising edge on
// gpio_cmdreg[0] launches WRITE1 / FILL / CLEAR (or flags the reserved
// mode); writes go out on BRAM port B and status returns on gpio_status.
// Optional read-back verify is compiled in with BRAM_LOADER_VERIFY_EN.
module bram_loader
  import bram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h0,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  gpio_cmdreg,
  input  logic [31:0] gpio_wdata,
  input  logic [31:0] bram_rd,
  output logic [31:0] bram_adr,
  output logic [31:0] bram_wdata,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic        done_pulse,
  output logic [7:0]  gpio_status
);

  logic start_rise;

  loader_state_t    state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             pulse_d;
  logic             en_d;
  logic [3:0]       we_d;
  logic [31:0]      adr_d, wdata_d;
  logic             access_d;
  logic             last_word;

`ifdef BRAM_LOADER_VERIFY_EN
  logic [7:0] wait_q, wait_d;
`else
  // Read-back port and latency only matter when verify is compiled in.
  logic unused_rd;
  assign unused_rd = ^{bram_rd, RD_LATENCY[0]};
`endif

  logic unused_cmd;
  assign unused_cmd = ^gpio_cmdreg[2:1];

  cmd_edge_detect u_start (
    .clk   (clk),
    .reset (reset),
    .level (gpio_cmdreg[0]),
    .rise  (start_rise)
  );

  // Next-state, sticky status and registered-output values for the coming edge.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    data_d   = data_q;
    done_d   = done_q;
    err_d    = err_q;
    ovr_d    = ovr_q;
    last_d   = last_q;
`ifdef BRAM_LOADER_VERIFY_EN
    wait_d   = wait_q;
`endif
    last_word = (mode_q == MODE_WRITE1) || (idx_q == IDX_W'(NUM_WORDS - 1));

    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          mode_d = mode_t'(gpio_cmdreg[7:6]);
          data_d = (mode_d == MODE_CLEAR) ? 32'd0 : gpio_wdata;
          idx_d  = (mode_d == MODE_WRITE1) ? gpio_cmdreg[5:3] : '0;
          done_d = 1'b0;
          err_d  = 1'b0;
          ovr_d  = 1'b0;
          if (mode_d == MODE_RSVD) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
`ifdef BRAM_LOADER_VERIFY_EN
        state_d = ST_VRD;
`else
        if (last_word) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WRITE;
          idx_d   = idx_q + 1'b1;
        end
`endif
      end
`ifdef BRAM_LOADER_VERIFY_EN
      ST_VRD: begin
        if (RD_LATENCY > 1) begin
          state_d = ST_VWAIT;
          wait_d  = 8'(RD_LATENCY - 2);
        end else begin
          state_d = ST_VCMP;
        end
      end
      ST_VWAIT: begin
        if (wait_q == 8'd0) state_d = ST_VCMP;
        else                wait_d  = wait_q - 8'd1;
      end
      ST_VCMP: begin
        if (bram_rd != data_q) err_d = 1'b1;
        if (last_word) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WRITE;
          idx_d   = idx_q + 1'b1;
        end
      end
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A start edge outside IDLE (DONE included) is dropped and remembered.
    if (start_rise && (state_q != ST_IDLE)) ovr_d = 1'b1;
    if (state_d == ST_DONE) done_d = 1'b1;
    // Last-index tracks each write but freezes once a verify error is seen.
    if ((state_d == ST_WRITE) && !err_d) last_d = idx_d;

    access_d = (state_d == ST_WRITE);
`ifdef BRAM_LOADER_VERIFY_EN
    access_d = access_d || (state_d == ST_VRD);
`endif
    en_d    = access_d;
    we_d    = (state_d == ST_WRITE) ? WE_ALL : 4'h0;
    adr_d   = access_d ? word_addr(ADDR_BASE, idx_d) : bram_adr;
    wdata_d = (state_d == ST_WRITE) ? data_d : bram_wdata;
    busy_d  = (state_d != ST_IDLE);
    pulse_d = (state_d == ST_DONE);
  end

  // State, command latches, sticky status and BRAM strobes all registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_WRITE1;
      idx_q      <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      last_q     <= '0;
      done_pulse <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= 4'h0;
      bram_adr   <= '0;
      bram_wdata <= '0;
`ifdef BRAM_LOADER_VERIFY_EN
      wait_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
      last_q     <= last_d;
      done_pulse <= pulse_d;
      bram_en    <= en_d;
      bram_we    <= we_d;
      bram_adr   <= adr_d;
      bram_wdata <= wdata_d;
`ifdef BRAM_LOADER_VERIFY_EN
      wait_q     <= wait_d;
`endif
    end
  end

  assign gpio_status = {1'b0, last_q, ovr_q, err_q, done_q, busy_q};

endmodule

// File: tb/tb_bram_loader.sv
// Self-checking bench for bram_loader (default build, verify disabled).
// Commands are described by mode/index/data; the expected write stream and
// final status come from a plain model of the command semantics.
module tb_bram_loader;

  localparam logic [31:0] ADDR_BASE  = 32'h0;
  localparam int          CMD_WINDOW = 20;

  typedef struct {
    int          r;
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  we;
  } wr_t;

  logic        clk;
  logic        reset;
  logic [7:0]  gpio_cmdreg;
  logic [31:0] gpio_wdata;
  logic [31:0] bram_rd;
  logic [31:0] bram_adr;
  logic [31:0] bram_wdata;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic        done_pulse;
  logic [7:0]  gpio_status;

  int       checks;
  int       failures;
  logic [2:0] model_last;

  bram_loader #(
    .ADDR_BASE  (ADDR_BASE),
    .RD_LATENCY (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .gpio_cmdreg (gpio_cmdreg),
    .gpio_wdata  (gpio_wdata),
    .bram_rd     (bram_rd),
    .bram_adr    (bram_adr),
    .bram_wdata  (bram_wdata),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .done_pulse  (done_pulse),
    .gpio_status (gpio_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command and compare the observed strobes and status with the model.
  task automatic run_cmd(input string name, input logic [1:0] mode,
                         input logic [2:0] idx, input logic [31:0] wd,
                         input int ovr_at);
    int         n;
    logic [2:0] first;
    logic [31:0] exp_data;
    logic [31:0] exp_adr;
    bit         exp_ovr;
    logic [7:0] exp_status;
    int         done_cnt;
    int         done_at;
    int         busy_cnt;
    wr_t        wl[$];

    // Model: which words this command writes and with what.
    case (mode)
      2'b00:   n = 1;
      2'b11:   n = 0;
      default: n = 8;
    endcase
    first    = (mode == 2'b00) ? idx : 3'd0;
    exp_data = (mode == 2'b10) ? 32'd0 : wd;
    exp_ovr  = (ovr_at >= 2) && (ovr_at <= n + 1);
    done_cnt = 0;
    done_at  = -1;
    busy_cnt = 0;

    @(negedge clk);
    gpio_cmdreg = {mode, idx, 3'b001};
    gpio_wdata  = wd;
    for (int r = 0; r < CMD_WINDOW; r++) begin
      @(negedge clk);
      if (bram_en) wl.push_back('{r, bram_adr, bram_wdata, bram_we});
      if (done_pulse) begin
        done_cnt++;
        done_at = r;
      end
      if (gpio_status[0]) busy_cnt++;
      if (r == 0) gpio_cmdreg[0] = 1'b0;
      if (ovr_at >= 2 && r == ovr_at - 1) gpio_cmdreg[0] = 1'b1;
      if (ovr_at >= 2 && r == ovr_at) gpio_cmdreg[0] = 1'b0;
      gpio_wdata = $urandom;
    end

    checks++;
    if (wl.size() != n) begin
      failures++;
      $display("FAIL %s write_count got=%0d want=%0d", name, wl.size(), n);
    end
    for (int k = 0; k < n && k < wl.size(); k++) begin
      exp_adr = ADDR_BASE + 32'(4 * (int'(first) + k));
      checks++;
      if (wl[k].r != k || wl[k].adr !== exp_adr || wl[k].data !== exp_data ||
          wl[k].we !== 4'hF) begin
        failures++;
        $display("FAIL %s write%0d got cyc=%0d adr=%h data=%h we=%h want cyc=%0d adr=%h data=%h we=f",
                 name, k, wl[k].r, wl[k].adr, wl[k].data, wl[k].we, k, exp_adr, exp_data);
      end
    end
    checks++;
    if (done_cnt != 1 || done_at != n) begin
      failures++;
      $display("FAIL %s done_pulse got count=%0d at=%0d want count=1 at=%0d",
               name, done_cnt, done_at, n);
    end
    checks++;
    if (busy_cnt != n + 1) begin
      failures++;
      $display("FAIL %s busy_cycles got=%0d want=%0d", name, busy_cnt, n + 1);
    end
    if (n > 0) model_last = first + 3'(n - 1);
    exp_status = {1'b0, model_last, exp_ovr, (mode == 2'b11), 1'b1, 1'b0};
    checks++;
    if (gpio_status !== exp_status) begin
      failures++;
      $display("FAIL %s status got=%b want=%b", name, gpio_status, exp_status);
    end
  endtask

  task automatic test_reset;
    reset       = 1'b0;
    gpio_cmdreg = 8'h00;
    gpio_wdata  = 32'h0;
    bram_rd     = 32'h0;
    model_last  = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bram_en, bram_we, done_pulse} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes got en=%b we=%h pulse=%b want 0", bram_en, bram_we, done_pulse);
    end
    checks++;
    if (bram_adr !== 32'h0 || bram_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus got adr=%h wdata=%h want 0", bram_adr, bram_wdata);
    end
    checks++;
    if (gpio_status !== 8'h00) begin
      failures++;
      $display("FAIL reset_status got=%b want=00000000", gpio_status);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (gpio_status !== 8'h00 || bram_en !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got status=%b en=%b want 0", gpio_status, bram_en);
    end
  endtask

  task automatic test_write1;
    run_cmd("write1", 2'b00, 3'd3, 32'hDEADBEEF, 0);
    checks++;
    if (gpio_status !== 8'b0_011_0010) begin
      failures++;
      $display("FAIL write1_status_const got=%b want=00110010", gpio_status);
    end
  endtask

  task automatic test_fill;
    run_cmd("fill", 2'b01, 3'd0, 32'h12345678, 0);
  endtask

  task automatic test_clear_rsvd;
    run_cmd("clear", 2'b10, 3'd5, 32'hFFFF_FFFF, 0);
    run_cmd("reserved", 2'b11, 3'd2, 32'hA5A5_A5A5, 0);
  endtask

  task automatic test_overrun;
    run_cmd("overrun_fill", 2'b01, 3'd0, 32'hCAFE_F00D, 3);
    run_cmd("overrun_done", 2'b00, 3'd6, 32'h0BAD_F00D, 2);
    run_cmd("after_overrun", 2'b00, 3'd1, 32'h1111_2222, 0);
  endtask

  task automatic test_random;
    logic [1:0] mode;
    int         n;
    int         ovr;
    for (int i = 0; i < 10; i++) begin
      mode = 2'($urandom_range(0, 3));
      n    = (mode == 2'b00) ? 1 : (mode == 2'b11) ? 0 : 8;
      ovr  = 0;
      if (n >= 1 && $urandom_range(0, 1) == 1) ovr = $urandom_range(2, n + 1);
      run_cmd($sformatf("rand%0d", i), mode, 3'($urandom_range(0, 7)), $urandom, ovr);
    end
  endtask

  task automatic test_reset_mid_fill;
    int strobes;
    @(negedge clk);
    gpio_cmdreg = 8'b01_000_001;
    gpio_wdata  = 32'h5555_AAAA;
    @(negedge clk);
    gpio_cmdreg[0] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bram_en !== 1'b1) begin
      failures++;
      $display("FAIL midfill_running got en=%b want=1", bram_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bram_en !== 1'b0 || bram_we !== 4'h0 || done_pulse !== 1'b0) begin
      failures++;
      $display("FAIL midfill_reset_strobes got en=%b we=%h pulse=%b want 0", bram_en, bram_we, done_pulse);
    end
    checks++;
    if (gpio_status !== 8'h00) begin
      failures++;
      $display("FAIL midfill_reset_status got=%b want=00000000", gpio_status);
    end
    @(negedge clk);
    reset      = 1'b1;
    model_last = 3'd0;
    strobes    = 0;
    repeat (12) begin
      @(negedge clk);
      if (bram_en) strobes++;
    end
    checks++;
    if (strobes != 0 || gpio_status !== 8'h00) begin
      failures++;
      $display("FAIL midfill_after_release got strobes=%0d status=%b want 0", strobes, gpio_status);
    end
    run_cmd("fill_after_reset", 2'b01, 3'd4, 32'h7777_0001, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write1();
    test_fill();
    test_clear_rsvd();
    test_overrun();
    test_random();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
